// File: rtl/box_motion_ctrl.sv
// Frame-synchronous box motion controller. Debounced buttons set per-axis accelerating speeds.
// The box moves once per vsync, is clamped to the active area, and gives a registered per-pixel hit flag.
module box_motion_ctrl #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int BOX_W           = 100,
    parameter int BOX_H           = 100,
    parameter int START_X         = 100,
    parameter int START_Y         = 100,
    parameter int MAX_SPEED       = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk_25mhz,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       vsync,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic       in_box,
    output logic       frame_tick
);

    localparam int          DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - BOX_W);
    localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - BOX_H);
    localparam logic [9:0]  X_START = 10'(START_X);
    localparam logic [9:0]  Y_START = 10'(START_Y);
    localparam logic [3:0]  SPD_MAX = 4'(MAX_SPEED);
    localparam logic [10:0] BOX_W11 = 11'(BOX_W);
    localparam logic [10:0] BOX_H11 = 11'(BOX_H);

    // Button bit order: [0]=up, [1]=down, [2]=left, [3]=right
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPEED  = 2'd1,
        ST_MOVE_X = 2'd2,
        ST_MOVE_Y = 2'd3
    } state_t;

    logic [3:0]            btn_sync1_q;
    logic [3:0]            btn_sync2_q;
    logic                  vs_sync1_q;
    logic                  vs_sync2_q;
    logic                  vs_prev_q;
    logic                  tick_s;
    logic                  frame_tick_q;

    logic [3:0][DB_W-1:0]  db_cnt_q;
    logic [3:0][DB_W-1:0]  db_cnt_d;
    logic [3:0]            db_state_q;
    logic [3:0]            db_state_d;

    state_t                state_q;
    logic [3:0]            dir_q;
    logic [3:0]            spd_x_q;
    logic [3:0]            spd_y_q;
    logic [3:0]            spd_x_d;
    logic [3:0]            spd_y_d;
    logic [9:0]            box_x_q;
    logic [9:0]            box_y_q;
    logic [9:0]            box_x_d;
    logic [9:0]            box_y_d;

    logic [10:0]           x_inc_s;
    logic [10:0]           y_inc_s;
    logic signed [10:0]    x_dec_s;
    logic signed [10:0]    y_dec_s;

    logic [10:0]           box_x_end_s;
    logic [10:0]           box_y_end_s;
    logic                  hit_s;
    logic                  in_box_q;

    // Two-flop synchronisers for the asynchronous buttons and vsync, plus the vsync edge history
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            btn_sync1_q  <= 4'b0000;
            btn_sync2_q  <= 4'b0000;
            vs_sync1_q   <= 1'b0;
            vs_sync2_q   <= 1'b0;
            vs_prev_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            btn_sync1_q  <= {btn_right, btn_left, btn_down, btn_up};
            btn_sync2_q  <= btn_sync1_q;
            vs_sync1_q   <= vsync;
            vs_sync2_q   <= vs_sync1_q;
            vs_prev_q    <= vs_sync2_q;
            frame_tick_q <= tick_s;
        end
    end

    assign tick_s = vs_sync2_q & ~vs_prev_q;

    // A button change is accepted only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_state_d = db_state_q;
        for (int i = 0; i < 4; i++) begin
            if (btn_sync2_q[i] == db_state_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i]   = '0;
                db_state_d[i] = btn_sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            db_cnt_q   <= '0;
            db_state_q <= 4'b0000;
        end else begin
            db_cnt_q   <= db_cnt_d;
            db_state_q <= db_state_d;
        end
    end

    // Speed update: exactly one direction accelerates, none or both opposing stop the axis
    always_comb begin
        spd_x_d = 4'd0;
        spd_y_d = 4'd0;
        if (db_state_q[B_RIGHT] ^ db_state_q[B_LEFT]) begin
            spd_x_d = (spd_x_q >= SPD_MAX) ? SPD_MAX : (spd_x_q + 4'd1);
        end else begin
            spd_x_d = 4'd0;
        end
        if (db_state_q[B_DOWN] ^ db_state_q[B_UP]) begin
            spd_y_d = (spd_y_q >= SPD_MAX) ? SPD_MAX : (spd_y_q + 4'd1);
        end else begin
            spd_y_d = 4'd0;
        end
    end

    // Clamped moves use 11-bit arithmetic so neither edge can wrap
    always_comb begin
        x_inc_s = {1'b0, box_x_q} + {7'b0000000, spd_x_q};
        y_inc_s = {1'b0, box_y_q} + {7'b0000000, spd_y_q};
        x_dec_s = $signed({1'b0, box_x_q}) - $signed({7'b0000000, spd_x_q});
        y_dec_s = $signed({1'b0, box_y_q}) - $signed({7'b0000000, spd_y_q});
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        if (dir_q[B_RIGHT] && !dir_q[B_LEFT]) begin
            box_x_d = (x_inc_s > {1'b0, X_MAX}) ? X_MAX : x_inc_s[9:0];
        end else if (dir_q[B_LEFT] && !dir_q[B_RIGHT]) begin
            box_x_d = (x_dec_s < 11'sd0) ? 10'd0 : x_dec_s[9:0];
        end else begin
            box_x_d = box_x_q;
        end
        if (dir_q[B_DOWN] && !dir_q[B_UP]) begin
            box_y_d = (y_inc_s > {1'b0, Y_MAX}) ? Y_MAX : y_inc_s[9:0];
        end else if (dir_q[B_UP] && !dir_q[B_DOWN]) begin
            box_y_d = (y_dec_s < 11'sd0) ? 10'd0 : y_dec_s[9:0];
        end else begin
            box_y_d = box_y_q;
        end
    end

    // Per-frame update sequence; a frame tick seen outside IDLE is dropped
    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 4'b0000;
            spd_x_q <= 4'd0;
            spd_y_q <= 4'd0;
            box_x_q <= X_START;
            box_y_q <= Y_START;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick_s) begin
                        state_q <= ST_SPEED;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SPEED: begin
                    dir_q   <= db_state_q;
                    spd_x_q <= spd_x_d;
                    spd_y_q <= spd_y_d;
                    state_q <= ST_MOVE_X;
                end
                ST_MOVE_X: begin
                    box_x_q <= box_x_d;
                    state_q <= ST_MOVE_Y;
                end
                ST_MOVE_Y: begin
                    box_y_q <= box_y_d;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Hit test: left/top inclusive, right/bottom exclusive
    always_comb begin
        box_x_end_s = {1'b0, box_x_q} + BOX_W11;
        box_y_end_s = {1'b0, box_y_q} + BOX_H11;
        hit_s = ({1'b0, x} >= {1'b0, box_x_q}) && ({1'b0, x} < box_x_end_s) &&
                ({1'b0, y} >= {1'b0, box_y_q}) && ({1'b0, y} < box_y_end_s);
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            in_box_q <= 1'b0;
        end else begin
            in_box_q <= hit_s;
        end
    end

    assign box_x      = box_x_q;
    assign box_y      = box_y_q;
    assign in_box     = in_box_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Scoreboard bench for box_motion_ctrl: stimulus queues expected positions/hit flags,
// monitors pop and compare on each frame_tick and on each probed pixel.
module tb_box_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       vsync;
    logic [9:0] x, y;
    logic [9:0] box_x, box_y;
    logic       in_box, frame_tick;

    typedef struct packed {
        logic [9:0] px;
        logic [9:0] py;
    } pos_t;

    pos_t pos_q[$];
    logic in_q[$];
    logic xy_valid = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #20 clk = ~clk;

    box_motion_ctrl #(
        .H_ACTIVE(640), .V_ACTIVE(480), .BOX_W(100), .BOX_H(100),
        .START_X(100), .START_Y(100), .MAX_SPEED(4), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_25mhz (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .vsync     (vsync),
        .x         (x),
        .y         (y),
        .box_x     (box_x),
        .box_y     (box_y),
        .in_box    (in_box),
        .frame_tick(frame_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame monitor: each frame_tick must be one cycle wide and settle to the queued position
    initial begin
        pos_t e;
        forever begin
            @(posedge clk); #1;
            if (frame_tick === 1'b1) begin
                @(posedge clk); #1;
                chk("tick_width", {31'd0, frame_tick}, 32'd0);
                repeat (3) @(posedge clk);
                #1;
                if (pos_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tick: got tick expected none");
                end else begin
                    e = pos_q.pop_front();
                    chk("box_x", {22'd0, box_x}, {22'd0, e.px});
                    chk("box_y", {22'd0, box_y}, {22'd0, e.py});
                end
            end
        end
    end

    // Pixel monitor: in_box is checked one cycle after x/y are presented
    initial begin
        logic e;
        forever begin
            @(posedge clk);
            if (xy_valid) begin
                #1;
                e = in_q.pop_front();
                chk("in_box", {31'd0, in_box}, {31'd0, e});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        repeat (10) @(negedge clk);
    endtask

    task automatic frame(input logic [9:0] ex, input logic [9:0] ey);
        pos_t p;
        p.px = ex;
        p.py = ey;
        pos_q.push_back(p);
        @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic probe(input logic [9:0] px, input logic [9:0] py, input logic exp);
        @(negedge clk);
        x = px;
        y = py;
        in_q.push_back(exp);
        xy_valid = 1'b1;
        @(negedge clk);
        xy_valid = 1'b0;
    endtask

    initial begin
        pos_t p;
        int   n;
        rst = 1'b1;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        vsync = 1'b0; x = 10'd0; y = 10'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_box_x", {22'd0, box_x}, 32'd100);
        chk("rst_box_y", {22'd0, box_y}, 32'd100);
        chk("rst_in_box", {31'd0, in_box}, 32'd0);
        chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        repeat (50) @(negedge clk);
        chk("idle_box_x", {22'd0, box_x}, 32'd100);

        // Hit-test edges with the box at (100,100)
        probe(10'd100, 10'd100, 1'b1);
        probe(10'd199, 10'd199, 1'b1);
        probe(10'd200, 10'd150, 1'b0);
        probe(10'd150, 10'd99,  1'b0);
        probe(10'd99,  10'd150, 1'b0);
        probe(10'd150, 10'd200, 1'b0);
        probe(10'd150, 10'd150, 1'b1);

        // Acceleration to the right, then release
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        frame(10'd101, 10'd100);
        frame(10'd103, 10'd100);
        frame(10'd106, 10'd100);
        frame(10'd110, 10'd100);
        frame(10'd114, 10'd100);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        frame(10'd114, 10'd100);

        // Opposing directions hold position
        set_btn(1'b0, 1'b0, 1'b1, 1'b1);
        frame(10'd114, 10'd100);
        frame(10'd114, 10'd100);
        frame(10'd114, 10'd100);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);

        // Short glitch on up is rejected
        @(negedge clk);
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        btn_up = 1'b0;
        repeat (10) @(negedge clk);
        frame(10'd114, 10'd100);

        // Step left twice from rest to land on 112
        set_btn(1'b0, 1'b0, 1'b1, 1'b0);
        frame(10'd113, 10'd100);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        frame(10'd113, 10'd100);
        set_btn(1'b0, 1'b0, 1'b1, 1'b0);
        frame(10'd112, 10'd100);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        frame(10'd112, 10'd100);

        // Long right ramp: reaches 538 at full speed, then clamps at 540
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        frame(10'd113, 10'd100);
        frame(10'd115, 10'd100);
        frame(10'd118, 10'd100);
        frame(10'd122, 10'd100);
        for (int i = 1; i <= 104; i++) begin
            n = 122 + 4 * i;
            frame(10'(n), 10'd100);
        end
        frame(10'd540, 10'd100);
        frame(10'd540, 10'd100);
        frame(10'd540, 10'd100);

        // Upward ramp clamps at 0 without wrapping
        set_btn(1'b1, 1'b0, 1'b0, 1'b0);
        frame(10'd540, 10'd99);
        frame(10'd540, 10'd97);
        frame(10'd540, 10'd94);
        frame(10'd540, 10'd90);
        for (int i = 1; i <= 22; i++) begin
            n = 90 - 4 * i;
            frame(10'd540, 10'(n));
        end
        frame(10'd540, 10'd0);
        frame(10'd540, 10'd0);
        frame(10'd540, 10'd0);

        // Reset in the middle of an update aborts it
        set_btn(1'b0, 1'b0, 1'b0, 1'b1);
        p.px = 10'd100;
        p.py = 10'd100;
        pos_q.push_back(p);
        @(negedge clk);
        vsync = 1'b1;
        n = 0;
        while (frame_tick !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_tick: got %0d expected 1", frame_tick);
        end
        @(negedge clk);
        rst = 1'b1;
        vsync = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        frame(10'd101, 10'd100);

        n = 0;
        while (pos_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("pending_frames", pos_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
